// File: rtl/id_ex_pkg.sv
// Shared widths, bundle field layout and pack/unpack helpers for the ID->EX stage.
// Field order from MSB: opcode, addr_mode, rd, rs1, rs2, dmem, imem, shamt.
package id_ex_pkg;

  localparam int unsigned OPC_W_DEF   = 5;
  localparam int unsigned REG_W_DEF   = 3;
  localparam int unsigned DMEM_AW_DEF = 4;
  localparam int unsigned IMEM_AW_DEF = 6;
  localparam int unsigned SHAMT_W_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 8;

  function automatic int unsigned bundle_w(input int unsigned opc_w, input int unsigned reg_w,
                                           input int unsigned dmem_aw, input int unsigned imem_aw,
                                           input int unsigned shamt_w);
    return opc_w + 1 + 3 * reg_w + dmem_aw + imem_aw + shamt_w;
  endfunction

  localparam int unsigned BUNDLE_W_DEF = bundle_w(OPC_W_DEF, REG_W_DEF, DMEM_AW_DEF,
                                                  IMEM_AW_DEF, SHAMT_W_DEF);

  localparam int unsigned SHAMT_LSB = 0;
  localparam int unsigned SHAMT_MSB = SHAMT_LSB + SHAMT_W_DEF - 1;
  localparam int unsigned IMEM_LSB  = SHAMT_MSB + 1;
  localparam int unsigned IMEM_MSB  = IMEM_LSB + IMEM_AW_DEF - 1;
  localparam int unsigned DMEM_LSB  = IMEM_MSB + 1;
  localparam int unsigned DMEM_MSB  = DMEM_LSB + DMEM_AW_DEF - 1;
  localparam int unsigned RS2_LSB   = DMEM_MSB + 1;
  localparam int unsigned RS2_MSB   = RS2_LSB + REG_W_DEF - 1;
  localparam int unsigned RS1_LSB   = RS2_MSB + 1;
  localparam int unsigned RS1_MSB   = RS1_LSB + REG_W_DEF - 1;
  localparam int unsigned RD_LSB    = RS1_MSB + 1;
  localparam int unsigned RD_MSB    = RD_LSB + REG_W_DEF - 1;
  localparam int unsigned AMODE_BIT = RD_MSB + 1;
  localparam int unsigned OPC_LSB   = AMODE_BIT + 1;
  localparam int unsigned OPC_MSB   = OPC_LSB + OPC_W_DEF - 1;

  typedef struct packed {
    logic [OPC_W_DEF-1:0]   opcode;
    logic                   addr_mode;
    logic [REG_W_DEF-1:0]   rd;
    logic [REG_W_DEF-1:0]   rs1;
    logic [REG_W_DEF-1:0]   rs2;
    logic [DMEM_AW_DEF-1:0] dmem_addr;
    logic [IMEM_AW_DEF-1:0] imem_addr;
    logic [SHAMT_W_DEF-1:0] shamt;
  } id_ex_bundle_t;

  function automatic logic [BUNDLE_W_DEF-1:0] pack(
      input logic [OPC_W_DEF-1:0] opcode, input logic addr_mode,
      input logic [REG_W_DEF-1:0] rd, input logic [REG_W_DEF-1:0] rs1,
      input logic [REG_W_DEF-1:0] rs2, input logic [DMEM_AW_DEF-1:0] dmem_addr,
      input logic [IMEM_AW_DEF-1:0] imem_addr, input logic [SHAMT_W_DEF-1:0] shamt);
    logic [BUNDLE_W_DEF-1:0] b;
    b                     = '0;
    b[OPC_MSB:OPC_LSB]    = opcode;
    b[AMODE_BIT]          = addr_mode;
    b[RD_MSB:RD_LSB]      = rd;
    b[RS1_MSB:RS1_LSB]    = rs1;
    b[RS2_MSB:RS2_LSB]    = rs2;
    b[DMEM_MSB:DMEM_LSB]  = dmem_addr;
    b[IMEM_MSB:IMEM_LSB]  = imem_addr;
    b[SHAMT_MSB:SHAMT_LSB] = shamt;
    return b;
  endfunction

  function automatic id_ex_bundle_t unpack(input logic [BUNDLE_W_DEF-1:0] b);
    id_ex_bundle_t s;
    s.opcode    = b[OPC_MSB:OPC_LSB];
    s.addr_mode = b[AMODE_BIT];
    s.rd        = b[RD_MSB:RD_LSB];
    s.rs1       = b[RS1_MSB:RS1_LSB];
    s.rs2       = b[RS2_MSB:RS2_LSB];
    s.dmem_addr = b[DMEM_MSB:DMEM_LSB];
    s.imem_addr = b[IMEM_MSB:IMEM_LSB];
    s.shamt     = b[SHAMT_MSB:SHAMT_LSB];
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register with synchronous flush. With PIPE_SKID_EN defined a
// second (skid) entry is added and in_ready becomes registered.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              main_can_load;
  logic              in_xfer;

  assign in_ready      = !skid_valid_q;
  assign main_can_load = !valid_q || out_ready;
  assign in_xfer       = in_valid && !skid_valid_q;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_can_load) begin
      // Skid entry is older than anything offered now, so it always goes first.
      if (skid_valid_q) begin
        data_d       = skid_data_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      data_d  = in_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register: valid/ready handshake, flush-to-bubble and a saturating
// stall counter. Define PIPE_SKID_EN for a 2-entry (skid-buffered) variant.
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned  OPC_W    = OPC_W_DEF,
  parameter int unsigned  REG_W    = REG_W_DEF,
  parameter int unsigned  DMEM_AW  = DMEM_AW_DEF,
  parameter int unsigned  IMEM_AW  = IMEM_AW_DEF,
  parameter int unsigned  SHAMT_W  = SHAMT_W_DEF,
  parameter int unsigned  CNT_W    = CNT_W_DEF,
  localparam int unsigned BUNDLE_W = bundle_w(OPC_W, REG_W, DMEM_AW, IMEM_AW, SHAMT_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUNDLE_W-1:0] in_bundle,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUNDLE_W-1:0] out_bundle,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic             in_valid_gated;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A flushing cycle must never accept the offered input, even with in_ready high.
  assign in_valid_gated = in_valid && !flush;

  pipe_skid_reg #(
    .DATA_W (BUNDLE_W)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid_gated),
    .in_ready  (in_ready),
    .in_data   (in_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Randomised bench for id_ex_pipe_stage against a queue-based model of the stage.
module tb_id_ex_pipe_stage;
  import id_ex_pkg::*;

  localparam int unsigned BW = BUNDLE_W_DEF;
`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush, out_ready;
  logic [BW-1:0] in_bundle;
  logic          in_ready, out_valid;
  logic [BW-1:0] out_bundle;
  logic [7:0]    stall_cnt;
  logic          in_ready3, out_valid3;
  logic [BW-1:0] out_bundle3;
  logic [2:0]    stall_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: FIFO of held entries, oldest at the front.
  logic [BW-1:0] mq[$];
  int            m_cnt;
  int            m_cnt3;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bundle  (in_bundle),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bundle (out_bundle),
    .stall_cnt  (stall_cnt)
  );

  id_ex_pipe_stage #(.CNT_W(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready3),
    .in_bundle  (in_bundle),
    .flush      (flush),
    .out_valid  (out_valid3),
    .out_ready  (out_ready),
    .out_bundle (out_bundle3),
    .stall_cnt  (stall_cnt3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_in_ready();
`ifdef PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit ov, ir;
    if (!rst) begin
      mq.delete();
      m_cnt  = 0;
      m_cnt3 = 0;
    end else begin
      ov = mq.size() > 0;
      ir = model_in_ready();
      if (ov && !out_ready) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir && mq.size() < CAP) mq.push_back(in_bundle);
      end
    end
  end

  always @(negedge clk) begin : compare
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("in_ready", 64'(in_ready), 64'(model_in_ready()));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    check("out_valid_w3", 64'(out_valid3), 64'(mq.size() > 0));
    check("stall_cnt_w3", 64'(stall_cnt3), 64'(m_cnt3));
    if (mq.size() > 0) check("out_bundle", 64'(out_bundle), 64'(mq[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] b_hold, b_skid;
    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_bundle = '0;
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bundle", 64'(out_bundle), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    step();

    // Single decoded instruction, latency 1.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_bundle = pack(5'h0A, 1'b0, 3'd3, 3'd1, 3'd2, 4'd0, 6'd0, 3'd0);
    #1;
    check("first_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_bundle_literal", 64'(out_bundle), 64'h5194000);
    check("first_opcode", 64'(unpack(out_bundle).opcode), 64'h0A);
    step();

    // Four back-to-back bundles; compare process checks order and no gaps.
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_bundle = pack(5'(i + 1), 1'b1, 3'(i), 3'(i + 1), 3'(i + 2), 4'(i), 6'(i * 3), 3'(i));
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Ten stalled cycles with one entry held.
    b_hold    = pack(5'h1F, 1'b1, 3'd7, 3'd6, 3'd5, 4'hC, 6'h2A, 3'd4);
    in_valid  = 1'b1;
    in_bundle = b_hold;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("stall10_cnt", 64'(stall_cnt), 64'd10);
    check("stall10_cnt_w3", 64'(stall_cnt3), 64'd7);
    check("stall10_bundle", 64'(out_bundle), 64'(b_hold));

`ifdef PIPE_SKID_EN
    b_skid    = pack(5'h03, 1'b0, 3'd1, 3'd2, 3'd3, 4'h5, 6'h11, 3'd6);
    in_valid  = 1'b1;
    in_bundle = b_skid;
    #1;
    check("skid_offer_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("skid_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("skid_first_out", 64'(out_bundle), 64'(b_hold));
    step();
    check("skid_second_out", 64'(out_bundle), 64'(b_skid));
    check("skid_second_valid", 64'(out_valid), 64'd1);
    check("skid_ready_back", 64'(in_ready), 64'd1);
    step();
`else
    b_skid    = '0;
    out_ready = 1'b1;
    #1;
    check("noskid_ready_comb", 64'(in_ready), 64'd1);
    check("noskid_skid_unused", 64'(b_skid), 64'(out_bundle & '0));
    step();
`endif
    check("after_drain_valid", 64'(out_valid), 64'd0);

    // Fill to capacity, then flush with a simultaneous offer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bundle = 28'h0AAAAAA;
    step();
    in_bundle = 28'h0555555;
    step();
    in_bundle = 28'h0F0F0F0;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("flush_no_ghost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset between edges while stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bundle = 28'h1234567;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_cnt", 64'(stall_cnt), 64'd0);
    check("async_rst_bundle", 64'(out_bundle), 64'd0);
    step();
    rst = 1'b1;

    // Random traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_bundle = BW'($urandom());
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
